// File: rtl/pkt_len_pkg.sv
// Shared types and constants for the packet length checker.
package pkt_len_pkg;

    typedef enum logic [1:0] {StIdle, StHdr, StBody} chk_state_e;

    localparam logic [7:0]  IOQ_CTRL = 8'hFF;
    localparam logic [7:0]  HDR_MIN  = 8'hF0;
    localparam int unsigned LEN_W    = 16;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small fallthrough FIFO: dout always shows the head entry while !empty.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   depth_q;
    logic                      do_wr, do_rd;

    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign full        = depth_q == (MAX_DEPTH_BITS+1)'(DEPTH);
    assign nearly_full = depth_q >= (MAX_DEPTH_BITS+1)'(DEPTH - 1);
    assign empty       = depth_q == '0;
    assign dout        = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_wr && !do_rd)      depth_q <= depth_q + 1'b1;
            else if (!do_wr && do_rd) depth_q <= depth_q - 1'b1;
        end
    end

endmodule

// File: rtl/pkt_len_checker.sv
// Pass-through stage that checks each packet's body word count against the
// IOQ header length field and keeps good/bad/stray statistics.
module pkt_len_checker
    import pkt_len_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned LEN_LSB    = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  clr_counters,
    output logic [CNT_WIDTH-1:0]  good_pkts,
    output logic [CNT_WIDTH-1:0]  bad_pkts,
    output logic [LEN_W-1:0]      stray_words,
    output logic [LEN_W-1:0]      last_bad_exp,
    output logic [LEN_W-1:0]      last_bad_obs
);

    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
    logic fifo_full, fifo_nearly_full, fifo_empty;
    logic pop, accept;

    assign pop    = !fifo_empty && out_rdy;
    assign accept = in_wr && !fifo_full;
    assign in_rdy = !fifo_nearly_full;

    fallthrough_small_fifo #(
        .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
        .MAX_DEPTH_BITS (2)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (pop),
        .dout        (fifo_dout),
        .full        (fifo_full),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= pop;
            if (pop) {out_ctrl, out_data} <= fifo_dout;
        end
    end

    // Word classification
    logic             is_hdr, is_ioq, is_body, is_eop;
    logic [LEN_W-1:0] hdr_len;

    assign is_hdr  = in_ctrl >= CTRL_WIDTH'(HDR_MIN);
    assign is_ioq  = in_ctrl == CTRL_WIDTH'(IOQ_CTRL);
    assign is_body = in_ctrl == '0;
    assign is_eop  = !is_hdr && !is_body;
    assign hdr_len = in_data[LEN_LSB +: LEN_W];

    chk_state_e       state_q;
    logic [LEN_W-1:0] exp_q, obs_q;
    logic             hv_q;

    logic             judge, force_bad, stray_inc, good_inc, bad_inc;
    logic [LEN_W-1:0] judge_obs;

    always_comb begin
        judge     = 1'b0;
        force_bad = 1'b0;
        stray_inc = 1'b0;
        judge_obs = obs_q;
        if (accept) begin
            unique case (state_q)
                StIdle: stray_inc = !is_hdr;
                StHdr: begin
                    judge     = is_eop;
                    judge_obs = LEN_W'(1);
                end
                StBody: begin
                    if (is_eop) begin
                        judge     = 1'b1;
                        judge_obs = sat_inc(obs_q);
                    end else if (is_hdr) begin
                        // New header cuts the packet short: always bad.
                        judge     = 1'b1;
                        force_bad = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign good_inc = judge && !force_bad && hv_q && (exp_q == judge_obs);
    assign bad_inc  = judge && !good_inc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            exp_q   <= '0;
            obs_q   <= '0;
            hv_q    <= 1'b0;
        end else if (accept) begin
            unique case (state_q)
                StIdle, StBody: begin
                    if (is_hdr) begin
                        state_q <= StHdr;
                        hv_q    <= is_ioq;
                        if (is_ioq) exp_q <= hdr_len;
                    end else if (state_q == StBody) begin
                        if (is_body) obs_q   <= sat_inc(obs_q);
                        else         state_q <= StIdle;
                    end
                end
                StHdr: begin
                    if (is_hdr) begin
                        if (is_ioq) begin
                            exp_q <= hdr_len;
                            hv_q  <= 1'b1;
                        end
                    end else if (is_body) begin
                        state_q <= StBody;
                        obs_q   <= LEN_W'(1);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr_counters) begin
            good_pkts    <= '0;
            bad_pkts     <= '0;
            stray_words  <= '0;
            last_bad_exp <= '0;
            last_bad_obs <= '0;
        end else begin
            good_pkts <= good_pkts + CNT_WIDTH'(good_inc);
            bad_pkts  <= bad_pkts + CNT_WIDTH'(bad_inc);
            if (stray_inc) stray_words <= sat_inc(stray_words);
            if (bad_inc) begin
                last_bad_exp <= exp_q;
                last_bad_obs <= judge_obs;
            end
        end
    end

endmodule

// File: tb/tb_pkt_len_checker.sv
// Scoreboarded bench: driver queues accepted words, monitor compares outputs.
module tb_pkt_len_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr, in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr, out_rdy, clr_counters;
    logic [31:0] good_pkts, bad_pkts;
    logic [15:0] stray_words, last_bad_exp, last_bad_obs;

    always #5 clk = ~clk;

    pkt_len_checker dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_wr        (in_wr),
        .in_rdy       (in_rdy),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_wr       (out_wr),
        .out_rdy      (out_rdy),
        .clr_counters (clr_counters),
        .good_pkts    (good_pkts),
        .bad_pkts     (bad_pkts),
        .stray_words  (stray_words),
        .last_bad_exp (last_bad_exp),
        .last_bad_obs (last_bad_obs)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sent     = 0;
    int          body_id  = 0;
    logic [71:0] exp_q [$];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic logic [63:0] mk_hdr(input logic [15:0] len);
        return {16'hA5C3, len, 32'h1234_5678};
    endfunction

    function automatic logic [63:0] mk_body();
        body_id++;
        return 64'h0BAD_F00D_0000_0000 | 64'(body_id);
    endfunction

    // Monitor: every presented output word must be the oldest queued input word.
    always @(negedge clk) begin
        if (reset && out_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {out_ctrl, out_data[55:0]}, 64'hx);
            end else begin
                logic [71:0] e;
                e = exp_q.pop_front();
                check("out_ctrl", 64'(out_ctrl), 64'(e[71:64]));
                check("out_data", out_data, e[63:0]);
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic [63:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_rdy && guard < 200) begin
            in_wr = 1'b0;
            guard++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            in_wr = 1'b0;
            check("send_timeout_in_rdy", 64'(in_rdy), 64'd1);
        end else begin
            in_ctrl = c;
            in_data = d;
            in_wr   = 1'b1;
            exp_q.push_back({c, d});
            sent++;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_wr = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_cnt(input string tag, input int g, input int b, input int s);
        check({tag, "_good"}, 64'(good_pkts), 64'(g));
        check({tag, "_bad"}, 64'(bad_pkts), 64'(b));
        check({tag, "_stray"}, 64'(stray_words), 64'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, stall_cnt;
        logic [63:0] h;
        reset = 1'b0; in_wr = 1'b0; in_ctrl = '0; in_data = '0;
        out_rdy = 1'b1; clr_counters = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_wr", 64'(out_wr), 64'd0);
        check_cnt("rst", 0, 0, 0);
        check("rst_lbe", 64'(last_bad_exp), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_rdy", 64'(in_rdy), 64'd1);

        // 1: good packet, 2-cycle latency on first word
        h = mk_hdr(16'd3);
        send(8'hFF, h);
        @(negedge clk);
        in_wr = 1'b0;
        check("lat_c1_out_wr", 64'(out_wr), 64'd0);
        @(negedge clk);
        check("lat_c2_out_wr", 64'(out_wr), 64'd1);
        check("lat_c2_data", out_data, h);
        send(8'h00, mk_body());
        send(8'h00, mk_body());
        send(8'h80, mk_body());
        idle(6);
        check_cnt("t1", 1, 0, 0);

        // 2: length mismatch
        send(8'hFF, mk_hdr(16'd5));
        send(8'h00, mk_body());
        send(8'h00, mk_body());
        send(8'h80, mk_body());
        idle(6);
        check_cnt("t2", 1, 1, 0);
        check("t2_lbe", 64'(last_bad_exp), 64'd5);
        check("t2_lbo", 64'(last_bad_obs), 64'd3);

        // 3: downstream stall during an 8-word packet
        @(negedge clk);
        out_rdy = 1'b0;
        base = sent;
        fork
            begin
                send(8'hFF, mk_hdr(16'd7));
                for (int i = 0; i < 6; i++) send(8'h00, mk_body());
                send(8'h80, mk_body());
                idle(1);
            end
            begin
                repeat (10) @(negedge clk);
                stall_cnt = sent - base;
                check("stall_in_rdy", 64'(in_rdy), 64'd0);
                check("stall_out_wr", 64'(out_wr), 64'd0);
                check("stall_accepted_3to4", 64'(stall_cnt >= 3 && stall_cnt <= 4), 64'd1);
                out_rdy = 1'b1;
            end
        join
        idle(8);
        check_cnt("t3", 2, 1, 0);

        // 4: eop-only body, non-IOQ header, header cutting a body short
        send(8'hFF, mk_hdr(16'd1));
        send(8'h01, mk_body());
        idle(5);
        check_cnt("t4a", 3, 1, 0);
        send(8'hFE, mk_hdr(16'd2));
        send(8'h00, mk_body());
        send(8'h80, mk_body());
        idle(5);
        check_cnt("t4b", 3, 2, 0);
        check("t4b_lbo", 64'(last_bad_obs), 64'd2);
        send(8'hFF, mk_hdr(16'd1));
        send(8'h00, mk_body());
        send(8'hFF, mk_hdr(16'd1));
        send(8'h01, mk_body());
        idle(5);
        check_cnt("t4c", 4, 3, 0);
        check("t4c_lbe", 64'(last_bad_exp), 64'd1);
        check("t4c_lbo", 64'(last_bad_obs), 64'd1);

        // 5: stray words, then clear coinciding with a good eop
        for (int i = 0; i < 3; i++) send(8'h00, mk_body());
        idle(5);
        check_cnt("t5_stray", 4, 3, 3);
        send(8'hFF, mk_hdr(16'd1));
        send(8'h01, mk_body());
        clr_counters = 1'b1;
        @(negedge clk);
        clr_counters = 1'b0;
        in_wr = 1'b0;
        repeat (4) @(negedge clk);
        check_cnt("t5_clr", 0, 0, 0);
        check("t5_lbe", 64'(last_bad_exp), 64'd0);
        check("t5_lbo", 64'(last_bad_obs), 64'd0);

        // 6: reset mid-packet, then a clean packet
        send(8'hFF, mk_hdr(16'd2));
        send(8'h01, mk_body());
        idle(5);
        check_cnt("t6_pre", 0, 1, 0);
        check("t6_lbe", 64'(last_bad_exp), 64'd2);
        send(8'hFF, mk_hdr(16'd2));
        send(8'h00, mk_body());
        idle(5);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_rst_out_wr", 64'(out_wr), 64'd0);
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_cnt("t6_rst", 0, 0, 0);
        check("t6_rst_lbe", 64'(last_bad_exp), 64'd0);
        send(8'hFF, mk_hdr(16'd2));
        send(8'h00, mk_body());
        send(8'h40, mk_body());
        idle(6);
        check_cnt("t6_post", 1, 0, 0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
